acumulador_ula: RTL and testbench

- Registered accumulator stage wrapped around the 4-bit ALU datapath: add, subtract, compare, complement.
- Holds operand A in an internal accumulator and takes operand B and an opcode from the bus.
- Writes the ALU result and flags back into registers, so chained operations (A := A op B) run without external storage.
- Adds a multi-cycle shift-and-add multiply built from the same adder.

---
 rtl/acumulador_ula.sv | 211 +++++++++++++++++++++
 tb/tb_acumulador_ula.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/acumulador_ula.sv
// rtl/acumulador_ula.sv - accumulator around a WIDTH-bit ALU with shift-add multiply (optional: ALU_SATURATE_EN)
module acumulador_ula #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             cout,
  output logic             ovfw,
  output logic             eq,
  output logic             gt,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               cout_q, cout_d;
  logic               ovfw_q, ovfw_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [2*WIDTH-1:0] prod_next;
  logic               prod_trunc;

  // ALU datapath shared by single-cycle ops and the multiply iteration
  always_comb begin
    add_sum    = {1'b0, acc_q} + {1'b0, b};
    sub_diff   = {1'b0, acc_q} - {1'b0, b};
    add_ovf    = (acc_q[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != acc_q[WIDTH-1]);
    sub_ovf    = (acc_q[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != acc_q[WIDTH-1]);
    prod_next  = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_trunc = |prod_next[2*WIDTH-1:WIDTH];
  end

  // Next-state and next-register computation for the IDLE/MUL/FIN controller
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cout_d   = cout_q;
    ovfw_d   = ovfw_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_LOAD: begin
              acc_d  = b;
              cout_d = 1'b0;
              ovfw_d = 1'b0;
              done_d = 1'b1;
            end
            OP_ADD: begin
`ifdef ALU_SATURATE_EN
              acc_d = add_sum[WIDTH] ? '1 : add_sum[WIDTH-1:0];
`else
              acc_d = add_sum[WIDTH-1:0];
`endif
              cout_d = add_sum[WIDTH];
              ovfw_d = add_ovf;
              done_d = 1'b1;
            end
            OP_SUB: begin
`ifdef ALU_SATURATE_EN
              acc_d = sub_diff[WIDTH] ? '0 : sub_diff[WIDTH-1:0];
`else
              acc_d = sub_diff[WIDTH-1:0];
`endif
              cout_d = sub_diff[WIDTH];
              ovfw_d = sub_ovf;
              done_d = 1'b1;
            end
            OP_CMP: begin
              eq_d   = (acc_q == b);
              gt_d   = (acc_q > b);
              done_d = 1'b1;
            end
            OP_NOT: begin
              acc_d  = ~acc_q;
              cout_d = 1'b0;
              ovfw_d = 1'b0;
              done_d = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, acc_q};
              mplier_d = b;
              prod_d   = '0;
              cnt_d    = CNT_W'(WIDTH - 1);
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            default: begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d   = prod_next;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // The last iteration writes the result directly so done lands WIDTH+1 edges after start
        if (cnt_q == '0) begin
`ifdef ALU_SATURATE_EN
          acc_d = prod_trunc ? '1 : prod_next[WIDTH-1:0];
`else
          acc_d = prod_next[WIDTH-1:0];
`endif
          ovfw_d  = prod_trunc;
          cout_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register bank; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cout_q   <= 1'b0;
      ovfw_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cout_q   <= cout_d;
      ovfw_q   <= ovfw_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign cout = cout_q;
  assign ovfw = ovfw_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign zero = (acc_q == '0);
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_acumulador_ula.sv
// tb/tb_acumulador_ula.sv - directed self-checking bench for acumulador_ula
module tb_acumulador_ula;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [3:0] b;
  logic [3:0] acc;
  logic       cout, ovfw, eq, gt, zero, busy, done, err;

  int total;
  int bad;
  int n;
  int pulses;

  acumulador_ula #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .b(b),
    .acc(acc), .cout(cout), .ovfw(ovfw), .eq(eq), .gt(gt),
    .zero(zero), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one start; returns positioned at the negedge after the start edge
  task automatic run_op(input logic [2:0] o, input logic [3:0] bv);
    start = 1'b1;
    op    = o;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, counting negedges since the start; n=99 on timeout
  task automatic wait_done(output int cnt);
    cnt = 1;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) cnt = 99;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    b     = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc", acc, 4'b0000);
    chk("rst_zero", zero, 1'b1);
    chk("rst_flags", {cout, ovfw, eq, gt, busy, done, err}, 7'b0);
    reset = 1'b0;
    @(negedge clk);

    // LOAD 0111, ADD 1001
    run_op(3'b000, 4'b0111);
    chk("load_done", done, 1'b1);
    chk("load_acc", acc, 4'b0111);
    run_op(3'b001, 4'b1001);
    chk("add1_acc", acc, SAT ? 4'b1111 : 4'b0000);
    chk("add1_flags", {cout, ovfw, zero, done}, {1'b1, 1'b0, !SAT, 1'b1});
    @(negedge clk);
    chk("add1_pulse", done, 1'b0);

    // signed overflow without carry, then borrow
    run_op(3'b000, 4'b0101);
    run_op(3'b001, 4'b0100);
    chk("add2_acc", acc, 4'b1001);
    chk("add2_flags", {cout, ovfw}, 2'b01);
    run_op(3'b000, 4'b0011);
    run_op(3'b010, 4'b0101);
    chk("sub_acc", acc, SAT ? 4'b0000 : 4'b1110);
    chk("sub_flags", {cout, ovfw}, 2'b10);

    // CMP and NOT
    run_op(3'b000, 4'b1001);
    run_op(3'b011, 4'b1001);
    chk("cmp1", {acc, eq, gt, cout, ovfw}, {4'b1001, 4'b1000});
    run_op(3'b011, 4'b0010);
    chk("cmp2", {eq, gt}, 2'b01);
    run_op(3'b100, 4'b0000);
    chk("not", {acc, eq, gt, done}, {4'b0110, 3'b011});

    // MUL 0110 * 0011 = 0001_0010
    run_op(3'b000, 4'b0110);
    run_op(3'b101, 4'b0011);
    chk("mul1_busy", {busy, done, acc}, {2'b10, 4'b0110});
    wait_done(n);
    chk("mul1_lat", n, 5);
    chk("mul1_res", {acc, ovfw, cout, busy}, {SAT ? 4'b1111 : 4'b0010, 3'b100});
    @(negedge clk);
    run_op(3'b000, 4'b0011);
    run_op(3'b101, 4'b0101);
    wait_done(n);
    chk("mul2_lat", n, 5);
    chk("mul2_res", {acc, ovfw}, {4'b1111, 1'b0});
    @(negedge clk);

    // start during busy and in FIN is ignored
    run_op(3'b000, 4'b0110);
    run_op(3'b101, 4'b0011);
    start = 1'b1;
    op    = 3'b000;
    b     = 4'b0000;
    wait_done(n);
    chk("ign_lat", n, 5);
    chk("ign_res", {acc, ovfw}, {SAT ? 4'b1111 : 4'b0010, 1'b1});
    @(negedge clk);
    start = 1'b0;
    chk("fin_ign", {acc, done}, {SAT ? 4'b1111 : 4'b0010, 1'b0});

    // reserved opcode
    run_op(3'b110, 4'b1010);
    chk("rsv", {err, done, acc, ovfw}, {2'b11, SAT ? 4'b1111 : 4'b0010, 1'b1});
    @(negedge clk);
    chk("rsv_pulse", {err, done}, 2'b00);

    // reset mid-multiply
    run_op(3'b000, 4'b0011);
    run_op(3'b101, 4'b0101);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_out", {acc, zero, cout, ovfw, eq, gt, busy, done, err}, {4'b0000, 1'b1, 7'b0});
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mrst_nodone", pulses, 0);
    run_op(3'b000, 4'b0001);
    chk("mrst_load", {acc, done, busy}, {4'b0001, 2'b10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
